// File: rtl/seven_seg_scan_decoder.sv
// Reads a multiplexed 4-digit seven-segment bus and rebuilds the displayed number.
// Reports the number as BCD and binary, with valid, change, error and stale flags.
module seven_seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_W          = 21
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [3:0]  anode_in,
  input  logic [6:0]  seg_in,
  output logic [15:0] value_bcd,
  output logic [13:0] value_bin,
  output logic        frame_valid,
  output logic        value_changed,
  output logic        frame_error,
  output logic        stale
);

  typedef enum logic [1:0] {SYNC_WAIT, COLLECT, EMIT} state_e;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [3:0]       anode_meta_q, anode_sync_q;
  logic [6:0]       seg_meta_q, seg_sync_q;
  logic [10:0]      bus_prev_q;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             bus_changed, sample;

  state_e           state_q;
  logic [1:0]       exp_pos_q;
  logic [3:0][3:0]  slot_q;
  logic [15:0]      value_bcd_q;
  logic [13:0]      value_bin_q;
  logic             frame_valid_q, value_changed_q, frame_error_q, stale_q, seen_q;

  logic             an_is_digit, an_is_blank;
  logic [1:0]       an_pos;
  logic             seg_ok;
  logic [3:0]       seg_digit;
  logic [13:0]      bin_calc;

  // Idle level of the active-low bus is all ones, so the synchronisers clear to
  // blanking and never present a spurious 0000 protocol code after reset.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      anode_meta_q <= '1;
      anode_sync_q <= '1;
      seg_meta_q   <= '1;
      seg_sync_q   <= '1;
      bus_prev_q   <= '1;
      settle_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes the two-stage synchroniser actually two stages.
      anode_meta_q <= anode_in;
      anode_sync_q <= anode_meta_q;
      seg_meta_q   <= seg_in;
      seg_sync_q   <= seg_meta_q;
      bus_prev_q   <= {anode_sync_q, seg_sync_q};
      settle_q     <= settle_d;
    end
  end

  assign bus_changed = ({anode_sync_q, seg_sync_q} != bus_prev_q);
  assign settle_d    = bus_changed ? '0 :
                       (settle_q == CNT_MAX) ? settle_q : settle_q + CNT_W'(1);
  // A change on the threshold cycle resets the count, so it also suppresses the sample.
  assign sample      = !bus_changed && (settle_d == SETTLE_LAST);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    an_is_digit = 1'b1;
    an_is_blank = 1'b0;
    an_pos      = 2'd0;
    case (anode_sync_q)
      4'b0111: an_pos = 2'd3;
      4'b1011: an_pos = 2'd2;
      4'b1101: an_pos = 2'd1;
      4'b1110: an_pos = 2'd0;
      4'b1111: begin an_is_digit = 1'b0; an_is_blank = 1'b1; end
      default: an_is_digit = 1'b0;
    endcase
  end

  always_comb begin
    seg_ok    = 1'b1;
    seg_digit = 4'd0;
    case (seg_sync_q)
      7'b0000001: seg_digit = 4'd0;
      7'b1001111: seg_digit = 4'd1;
      7'b0010010: seg_digit = 4'd2;
      7'b0000110: seg_digit = 4'd3;
      7'b1001100: seg_digit = 4'd4;
      7'b0100100: seg_digit = 4'd5;
      7'b0100000: seg_digit = 4'd6;
      7'b0001111: seg_digit = 4'd7;
      7'b0000000: seg_digit = 4'd8;
      7'b0000100: seg_digit = 4'd9;
      default:    seg_ok    = 1'b0;
    endcase
  end

  assign bin_calc = 14'(slot_q[3]) * 14'd1000 + 14'(slot_q[2]) * 14'd100 +
                    14'(slot_q[1]) * 14'd10   + 14'(slot_q[0]);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q         <= SYNC_WAIT;
      exp_pos_q       <= 2'd3;
      // NOTE: the digit slots are ordinary flops, so they are cleared here and a
      // reset mid-frame cannot leak partial digits into a later frame.
      slot_q          <= '0;
      value_bcd_q     <= '0;
      value_bin_q     <= '0;
      frame_valid_q   <= 1'b0;
      value_changed_q <= 1'b0;
      frame_error_q   <= 1'b0;
      seen_q          <= 1'b0;
    end else begin
      frame_valid_q   <= 1'b0;
      value_changed_q <= 1'b0;
      frame_error_q   <= 1'b0;
      case (state_q)
        SYNC_WAIT: begin
          if (sample) begin
            if (an_is_digit && an_pos == 2'd3 && seg_ok) begin
              slot_q[3] <= seg_digit;
              exp_pos_q <= 2'd2;
              state_q   <= COLLECT;
            end else if (!an_is_digit && !an_is_blank) begin
              frame_error_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (sample && !an_is_blank) begin
            if (an_is_digit && an_pos == exp_pos_q && seg_ok) begin
              slot_q[exp_pos_q] <= seg_digit;
              if (exp_pos_q == 2'd0) state_q   <= EMIT;
              else                   exp_pos_q <= exp_pos_q - 2'd1;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= SYNC_WAIT;
            end
          end
        end
        EMIT: begin
          value_bcd_q     <= slot_q;
          value_bin_q     <= bin_calc;
          frame_valid_q   <= 1'b1;
          value_changed_q <= !seen_q || (slot_q != value_bcd_q);
          seen_q          <= 1'b1;
          state_q         <= SYNC_WAIT;
        end
        default: state_q <= SYNC_WAIT;
      endcase
    end
  end

  // The timeout restarts on the emit edge; stale drops only once the pulse is visible.
  assign to_cnt_d = (state_q == EMIT) ? '0 :
                    (to_cnt_q == TIMEOUT_MAX) ? to_cnt_q : to_cnt_q + CNT_W'(1);

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      stale_q  <= 1'b1;
    end else begin
      to_cnt_q <= to_cnt_d;
      stale_q  <= frame_valid_q ? 1'b0 : (stale_q || (to_cnt_d == TIMEOUT_MAX));
    end
  end

  assign value_bcd     = value_bcd_q;
  assign value_bin     = value_bin_q;
  assign frame_valid   = frame_valid_q;
  assign value_changed = value_changed_q;
  assign frame_error   = frame_error_q;
  assign stale         = stale_q;

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
Monitors a multiplexed 4-digit seven-segment bus (anode strobes plus cathode patterns) and reconstructs the displayed decimal number. It is the reading end of the display controller's output interface. It is used for on-board self-check and loop-back of display drivers, and reports the value as BCD and binary with valid, change and error flags.

Parameters:
SETTLE_CYCLES, 16, consecutive stable cycles required on anode_in/seg_in before a digit is sampled
TIMEOUT_CYCLES, 1048576, cycles without a valid frame before stale asserts
CNT_W, 21, width of the settle and timeout counters; must hold TIMEOUT_CYCLES

Ports:
clock_100Mhz  in   1   system clock
reset         in   1   asynchronous, active-high reset
anode_in      in   4   active-low digit strobes: 0111=thousands, 1011=hundreds, 1101=tens, 1110=ones
seg_in        in   7   active-low cathodes, bit6=a … bit0=g
value_bcd     out  16  last valid frame, [15:12] thousands … [3:0] ones
value_bin     out  14  binary equivalent of value_bcd (0..9999)
frame_valid   out  1   one-cycle pulse when a complete, error-free frame is captured
value_changed out  1   one-cycle pulse coincident with frame_valid when the value differs from the previous frame
frame_error   out  1   one-cycle pulse on a protocol or pattern error
stale         out  1   level; high when no valid frame has occurred within TIMEOUT_CYCLES

Behaviour:
- Interface: reset is asynchronous, active-high. All logic is clocked on clock_100Mhz.
- Reset values: value_bcd=0, value_bin=0, frame_valid=0, value_changed=0, frame_error=0, stale=1. The synchronisers, counters and digit slots clear. The FSM enters SYNC_WAIT. A reset mid-frame discards all partial data.
- Input path: anode_in and seg_in pass through 2-flop synchronisers. All subsequent logic uses the synchronised copies.
- Settle counter:
  - Resets to 0 on any change of the {anode,seg} synchronised value versus the previous cycle; otherwise increments, saturating.
  - A digit is sampled exactly once per anode dwell, on the cycle the counter reaches SETTLE_CYCLES-1.
  - If a change occurs in the same cycle the count would be reached, the change wins and no sample is taken.
- Anode classification:
  - One of the four one-hot-low codes selects a digit.
  - 1111 is blanking: ignored, no sample, no error.
  - Any other code (multiple low, or 0000) is a protocol error once settled.
- Segment decode: standard patterns 0–9 (e.g. 0000001="0", 1001111="1", 0000100="9"). Any other pattern is a pattern error.
- FSM:
  - SYNC_WAIT: waits for a settled thousands digit. A valid sample stores it into slot3, then goes to COLLECT with expected=hundreds. Other digit codes are ignored silently; this is alignment, not an error.
  - COLLECT: each settled sample must carry the expected digit code, in order thousands→hundreds→tens→ones.
    - A correct sample stores into its slot.
    - A wrong digit order, protocol error or pattern error pulses frame_error for 1 cycle and returns to SYNC_WAIT.
    - Storing the ones digit goes to EMIT.
  - EMIT (1 cycle):
    - value_bcd <= slots.
    - value_bin <= d3*1000 + d2*100 + d1*10 + d0, computed in 14 bits with no overflow possible.
    - frame_valid pulses.
    - value_changed pulses if the new value_bcd differs from the old one, or if this is the first valid frame since reset.
    - Next state is SYNC_WAIT.
- Latency: outputs update, and frame_valid asserts, on the clock edge one cycle after the ones-digit sample.
- value_bcd and value_bin hold their values between frames and on error.
- Timeout counter:
  - Clears on frame_valid; otherwise increments, saturating at TIMEOUT_CYCLES.
  - stale=1 while the counter equals TIMEOUT_CYCLES, or before the first valid frame.
  - stale=0 starting the cycle after frame_valid.
- Simultaneous events: an error and EMIT cannot coincide. frame_error and frame_valid are never both high.

Test Plan:
1. Bench with SETTLE_CYCLES=4, TIMEOUT_CYCLES=64. Drive the scan 0111/"1", 1011/"2", 1101/"3", 1110/"4", 20 cycles per digit. Required: value_bcd=16'h1234, value_bin=1234, frame_valid and value_changed each a single pulse.
2. Repeat the 1234 frame. Required: frame_valid pulses and value_changed stays 0. Then drive 9999. Required: value_bin=9999 and value_changed=1.
3. Start the scan at tens, then run full frames of 0507. Required: partial digits ignored, no frame_error, value_bcd=16'h0507.
4. Drive seg 1111111 on the hundreds digit, then separately anode 0011. Required: frame_error pulses for 1 cycle each time, and value_bcd retains 16'h0507.
5. Toggle seg every 2 cycles (never settled) for 100 cycles. Required: no sample taken, and stale=1 from cycle 64 after the last frame_valid. A valid frame then clears stale.
6. Assert reset mid-COLLECT after two digits. Required: all outputs return to reset values immediately and stale=1. The next full frame of 0042 yields value_bin=42 and value_changed=1.
